dual_switch_lamp: RTL and testbench
===================================

DUAL_SWITCH_LAMP -- requirements
Module: dual_switch_lamp

Interface
REQ-001 SHALL have parameter DB_CYCLES, default 16: consecutive stable cycles required to accept a debounced input change; legal range 2..2^20.
REQ-002 SHALL have parameter CNT_W, default 8: width of toggle_cnt.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous assert, active-low; release synchronous to clk.
REQ-005 SHALL have port btn_a  input  1  raw station-A button, active-high, asynchronous, may bounce.
REQ-006 SHALL have port btn_b  input  1  raw station-B button, same properties as btn_a.
REQ-007 SHALL have port clr  input  1  synchronous clear of lamp and toggle_cnt.
REQ-008 SHALL have port lamp  output  1  lamp state, registered.
REQ-009 SHALL have port press_a  output  1  one-cycle pulse on accepted station-A press.
REQ-010 SHALL have port press_b  output  1  one-cycle pulse on accepted station-B press.
REQ-011 SHALL have port toggle_cnt  output  CNT_W  count of lamp transitions, registered.

Function
REQ-012 SHALL pass each raw button through a 2-flop synchronizer; s_x denotes the second-flop output.
REQ-013 SHALL keep a per-channel debounced state db_x and counter dc_x, width ceil(log2(DB_CYCLES)).
REQ-014 While s_x == db_x, dc_x SHALL hold 0.
REQ-015 While s_x != db_x and dc_x < DB_CYCLES-1, dc_x SHALL increment by 1.
REQ-016 When s_x != db_x and dc_x == DB_CYCLES-1, db_x SHALL take s_x and dc_x SHALL return to 0.
REQ-017 A mismatch lasting fewer than DB_CYCLES cycles SHALL leave db_x unchanged and restart the count on its next occurrence from 0.
REQ-018 press_x SHALL be 1 exactly in the cycle where db_x == 1 and db_x of the previous cycle == 0; releases SHALL generate no pulse.
REQ-019 On a clock edge with clr == 0 and exactly one of press_a, press_b high, lamp SHALL invert and toggle_cnt SHALL increment by 1.
REQ-020 On a clock edge with press_a and press_b both high, lamp and toggle_cnt SHALL hold; the two toggles cancel.
REQ-021 toggle_cnt SHALL wrap from 2^CNT_W-1 to 0 with no saturation and no flag.
REQ-022 On a clock edge with clr == 1, lamp and toggle_cnt SHALL become 0 regardless of presses in that cycle; synchronizers, debouncers and press pulses SHALL be unaffected by clr.
REQ-023 Latency: if btn_x rises before edge E0 and then stays high, with db_x == 0 and a stable low history, s_x SHALL be 1 after E1. db_x SHALL be 1 after E(1+DB_CYCLES). press_x SHALL be high in the following cycle. lamp SHALL change at E(2+DB_CYCLES).
REQ-024 Holding a button SHALL produce exactly one press; another press requires a debounced release (REQ-016 path to 0) followed by a debounced press.

Reset
REQ-025 While rst == 0, SHALL force synchronizer flops, db_x, delayed db_x and dc_x to 0, lamp to 0 and toggle_cnt to 0; press_a and press_b SHALL read 0.
REQ-026 Reset asserted mid-debounce SHALL discard the partial count; a button already held at reset release SHALL be accepted as a new press after the full REQ-023 latency.
REQ-027 SHALL produce no press pulse in the first cycle after reset release.

Verification (DB_CYCLES=4, CNT_W=8)
REQ-028 SHALL verify: btn_a held high from reset release -> lamp 0->1 at edge 6 after the first sampling edge, press_a high for exactly 1 cycle, toggle_cnt = 1.
REQ-029 SHALL verify: btn_b glitches high for 3 cycles, then low 10 cycles -> no press_b, lamp and toggle_cnt unchanged.
REQ-030 SHALL verify: btn_a and btn_b rise in the same cycle and are held -> press_a and press_b both pulse in the same cycle, lamp unchanged, toggle_cnt unchanged.
REQ-031 SHALL verify: 256 alternating debounced A/B presses from reset -> lamp = 0, toggle_cnt wraps to 0; a 257th press -> lamp = 1, toggle_cnt = 1.
REQ-032 SHALL verify: clr = 1 in the same cycle as press_a with lamp = 1, toggle_cnt = 5 -> next cycle lamp = 0, toggle_cnt = 0.
REQ-033 SHALL verify: rst pulsed low while dc_a = 2 and btn_a held -> all outputs 0 during reset; after release press_a arrives after the full latency, lamp = 1, toggle_cnt = 1.

Source files
------------

// File: rtl/dual_switch_lamp.sv
// -----------------------------------------------------------------------------
// dual_switch_lamp
//
// Two-way lamp switch with two button stations (A and B). A debounced
// press from exactly one station toggles the lamp and advances a
// transition counter. Simultaneous presses cancel each other.
//
// Each raw button passes through a 2-flop synchronizer and then a
// stability-counting debouncer. A press pulse is the rising edge of the
// debounced level, so holding a button produces exactly one press.
//
// Parameters
//   DB_CYCLES : consecutive stable cycles needed to accept a change (2..2^20)
//   CNT_W     : width of toggle_cnt
//
// Ports
//   clk        in   sole clock, rising edge
//   rst        in   asynchronous active-low reset, released synchronously
//   btn_a      in   raw station-A button, active-high, may bounce
//   btn_b      in   raw station-B button, active-high, may bounce
//   clr        in   synchronous clear of lamp and toggle_cnt
//   lamp       out  lamp state (registered)
//   press_a    out  one-cycle pulse on an accepted station-A press
//   press_b    out  one-cycle pulse on an accepted station-B press
//   toggle_cnt out  count of lamp transitions, wraps (registered)
// -----------------------------------------------------------------------------
module dual_switch_lamp #(
  parameter int DB_CYCLES = 16,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_a,
  input  logic             btn_b,
  input  logic             clr,
  output logic             lamp,
  output logic             press_a,
  output logic             press_b,
  output logic [CNT_W-1:0] toggle_cnt
);

  localparam int              DC_W   = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [DC_W-1:0] DC_MAX = DC_W'(DB_CYCLES - 1);

  // Channel index 0 is station A, index 1 is station B.
  logic [1:0]           sync1_q, sync1_d;
  logic [1:0]           sync2_q, sync2_d;
  logic [1:0]           db_q, db_d;
  logic [1:0]           db_dly_q, db_dly_d;
  logic [1:0][DC_W-1:0] dc_q, dc_d;
  logic                 lamp_q, lamp_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [1:0]           press;

  // Press is the rising edge of the debounced level; both operands are
  // flops, so the pulse is glitch-free and reads 0 while in reset.
  assign press = db_q & ~db_dly_q;

  // NOTE: every signal assigned here gets a default on entry, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    sync1_d  = {btn_b, btn_a};
    sync2_d  = sync1_q;
    db_dly_d = db_q;
    db_d     = db_q;
    dc_d     = '0;

    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != db_q[i]) begin
        if (dc_q[i] == DC_MAX) begin
          db_d[i] = sync2_q[i];
          dc_d[i] = '0;
        end else begin
          dc_d[i] = dc_q[i] + DC_W'(1);
        end
      end
      // A match holds the counter at 0, so a short glitch that ends
      // restarts from 0 on its next occurrence.
    end

    lamp_d = lamp_q;
    cnt_d  = cnt_q;
    if (clr) begin
      lamp_d = 1'b0;
      cnt_d  = '0;
    end else if (press[0] ^ press[1]) begin
      // Both stations in the same cycle are two toggles that cancel.
      lamp_d = ~lamp_q;
      cnt_d  = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      db_q     <= '0;
      db_dly_q <= '0;
      dc_q     <= '0;
      lamp_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      db_q     <= db_d;
      db_dly_q <= db_dly_d;
      dc_q     <= dc_d;
      lamp_q   <= lamp_d;
      cnt_q    <= cnt_d;
    end
  end

  assign lamp       = lamp_q;
  assign toggle_cnt = cnt_q;
  assign press_a    = press[0];
  assign press_b    = press[1];

endmodule

// File: tb/tb_dual_switch_lamp.sv
// -----------------------------------------------------------------------------
// tb_dual_switch_lamp
//
// Directed bench for dual_switch_lamp with DB_CYCLES=4, CNT_W=8. Expected
// values are pushed to a scoreboard queue when stimulus is applied and
// popped when the corresponding DUT output is sampled (#1 after the
// rising edge).
// -----------------------------------------------------------------------------
module tb_dual_switch_lamp;

  localparam int DB = 4;
  localparam int CW = 8;
  // Edges from a button rising (just after an edge) to the press pulse:
  // 2 synchronizer edges + DB-1 counting edges + 1 accept edge.
  localparam int PRESS_LAT = DB + 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          btn_a;
  logic          btn_b;
  logic          clr;
  logic          lamp;
  logic          press_a;
  logic          press_b;
  logic [CW-1:0] toggle_cnt;

  dual_switch_lamp #(
    .DB_CYCLES (DB),
    .CNT_W     (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_a      (btn_a),
    .btn_b      (btn_b),
    .clr        (clr),
    .lamp       (lamp),
    .press_a    (press_a),
    .press_b    (press_b),
    .toggle_cnt (toggle_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t          sb[$];
  int            n_checks = 0;
  int            n_errors = 0;
  logic          exp_lamp;
  logic [CW-1:0] exp_cnt;

  task automatic expect_val(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    n_checks++;
    if (sb.size() == 0) begin
      n_errors++;
      $display("FAIL scoreboard_empty: observed=%0h", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        n_errors++;
        $error("FAIL %s: observed=%0h expected=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Returns the number of edges until the selected press pulse is seen,
  // or 0 if it does not appear within the budget.
  task automatic wait_press(input bit use_b, output int lat);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      tick(1);
      if ((use_b ? press_b : press_a) === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  // One full debounced press and release on one station; updates the model.
  task automatic press_once(input bit use_b);
    int lat;
    if (use_b) btn_b = 1'b1; else btn_a = 1'b1;
    expect_val(use_b ? "press_b_latency" : "press_a_latency", PRESS_LAT);
    wait_press(use_b, lat);
    check(lat);
    tick(1);
    exp_lamp = ~exp_lamp;
    exp_cnt  = exp_cnt + CW'(1);
    if (use_b) btn_b = 1'b0; else btn_a = 1'b0;
    tick(10);
  endtask

  task automatic check_outputs(input string tag);
    expect_val({tag, "_lamp"}, 32'(exp_lamp));
    check(32'(lamp));
    expect_val({tag, "_cnt"}, 32'(exp_cnt));
    check(32'(toggle_cnt));
  endtask

  initial begin
    int lat;
    logic any;

    rst   = 1'b0;
    btn_a = 1'b0;
    btn_b = 1'b0;
    clr   = 1'b0;
    exp_lamp = 1'b0;
    exp_cnt  = '0;

    // ---- Reset state, then A held from reset release ----
    tick(3);
    check_outputs("reset");
    btn_a = 1'b1;
    tick(2);
    expect_val("reset_press_a", 0); check(32'(press_a));
    expect_val("reset_press_b", 0); check(32'(press_b));
    rst = 1'b1;
    expect_val("held_a_latency", PRESS_LAT);
    wait_press(1'b0, lat);
    check(lat);
    tick(1);
    exp_lamp = 1'b1;
    exp_cnt  = 8'd1;
    expect_val("held_a_pulse_width", 0); check(32'(press_a));
    check_outputs("held_a");
    btn_a = 1'b0;
    tick(10);

    // ---- B glitch of 3 cycles is rejected ----
    any   = 1'b0;
    btn_b = 1'b1;
    for (int i = 0; i < 3; i++) begin tick(1); any |= press_b; end
    btn_b = 1'b0;
    for (int i = 0; i < 10; i++) begin tick(1); any |= press_b; end
    expect_val("glitch_no_press_b", 0); check(32'(any));
    check_outputs("glitch");

    // ---- Simultaneous A and B presses cancel ----
    btn_a = 1'b1;
    btn_b = 1'b1;
    expect_val("both_latency", PRESS_LAT);
    wait_press(1'b0, lat);
    check(lat);
    expect_val("both_press_b", 1); check(32'(press_b));
    tick(1);
    check_outputs("both");
    btn_a = 1'b0;
    btn_b = 1'b0;
    tick(10);

    // ---- Reach lamp=1, cnt=5, then clr during a press ----
    press_once(1'b1);
    press_once(1'b0);
    press_once(1'b1);
    press_once(1'b0);
    check_outputs("pre_clr");
    btn_a = 1'b1;
    expect_val("clr_press_latency", PRESS_LAT);
    wait_press(1'b0, lat);
    check(lat);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    exp_lamp = 1'b0;
    exp_cnt  = '0;
    check_outputs("clr");
    btn_a = 1'b0;
    tick(10);

    // ---- Wrap: 256 alternating presses from reset, then one more ----
    rst = 1'b0;
    tick(2);
    rst = 1'b1;
    exp_lamp = 1'b0;
    exp_cnt  = '0;
    tick(2);
    for (int i = 0; i < 255; i++) press_once(i[0]);
    check_outputs("press255");
    press_once(1'b1);
    check_outputs("wrap256");
    press_once(1'b0);
    check_outputs("press257");

    // ---- Reset mid-debounce with A held ----
    btn_a = 1'b1;
    tick(4);           // synchronizer filled, debounce counter at 2
    #2 rst = 1'b0;     // asynchronous assertion between edges
    #1;
    expect_val("mid_rst_lamp", 0);    check(32'(lamp));
    expect_val("mid_rst_cnt", 0);     check(32'(toggle_cnt));
    expect_val("mid_rst_press_a", 0); check(32'(press_a));
    expect_val("mid_rst_press_b", 0); check(32'(press_b));
    tick(3);
    rst = 1'b1;
    expect_val("post_rst_latency", PRESS_LAT);
    wait_press(1'b0, lat);
    check(lat);
    tick(1);
    exp_lamp = 1'b1;
    exp_cnt  = 8'd1;
    check_outputs("post_rst");
    btn_a = 1'b0;
    tick(10);

    if (sb.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard_leftover: observed=%0d expected=0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "simulation time limit reached");
  end

endmodule
